spn_cfg_stream: RTL and testbench
=================================

# spn_cfg_stream

Runtime-configurable streaming permutation network: successor to the fixed-table 16×16 SPN, generalised in channel count, frame depth and data width. Each frame of DEPTH beats × PARA words passes through a spatial permutation, a per-channel temporal permutation in ping-pong RAM, and a second spatial permutation. Control tables load at runtime through a config port; an explicit flush drains the last frame without dummy-image padding. Sits between the stream DMA and the CNN compute array, as the fixed SPN did.

## Interface
- PARA, 16, channels (words per beat); power of 2, ≥2
- DEPTH, 16, beats per frame; power of 2, ≥2
- DATA_WIDTH, 32, bits per word
- Derived: SEL_W = $clog2(PARA), ADDR_W = $clog2(DEPTH), CFG_W = max(SEL_W, ADDR_W)

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset
- valid_in  in  1  input beat valid; gaps allowed
- in_ready  out  1  beat accepted iff valid_in && in_ready
- data_in  in  PARA×DATA_WIDTH  unpacked array, word c = channel c
- flush  in  1  drain request (single-cycle pulse)
- valid_out  out  1  output beat valid
- data_out  out  PARA×DATA_WIDTH  permuted output beat
- busy  out  1  frame buffered or pipeline occupied
- cfg_wen  in  1  table write strobe
- cfg_table  in  2  0=perm0, 1=mem, 2=perm2, 3=reserved (ignored)
- cfg_beat  in  ADDR_W  beat index t
- cfg_chan  in  SEL_W  channel c
- cfg_data  in  CFG_W  entry; low SEL_W bits (perm) or ADDR_W bits (mem) used
- cfg_err  out  1  one-cycle pulse: write rejected

## Operation
- Tables: perm0[t][c], perm2[t][c] (SEL_W, source channel for output channel c at beat t); wr_addr[t][c] (ADDR_W, write slot of channel c's word at beat t). Reset value identity: perm[t][c]=c, wr_addr[t][c]=t.
- Stage 0: m[c] = data_in[perm0[t][c]], t = input beat counter.
- Stage 1: per channel, write m[c] to bank wb at wr_addr[t][c]; read bank rb=!wb at slot t. Banks swap when t wraps DEPTH-1→0.
- Stage 2: data_out[c] = r[perm2[t][c]], t = the read beat index.
- Output frame k = frame k−1 permuted; frame 0 produces no valid outputs.
- FSM: EMPTY → FILL on first accepted beat; FILL → STREAM after beat DEPTH−1; STREAM → FLUSH on flush when t==0 and valid_in low (otherwise flush ignored); FLUSH issues DEPTH internal beats, one per cycle, writes inhibited, read bank rb → EMPTY after last.
- in_ready = 0 only in FLUSH.
- cfg_wen accepted only when busy==0; otherwise table unchanged and cfg_err pulses next cycle. cfg_table==3: ignored, no error.
- Non-permutation tables: data undefined, control flow unaffected.
- busy = state≠EMPTY or any pipeline valid bit set.

## Timing
- Reset (async): valid_out 0, data_out 0, busy 0, in_ready 1, cfg_err 0, state EMPTY, t 0, wb 0, tables identity.
- Latency 3 cycles: beat accepted at cycle n → stage-0 register n+1 → RAM read data n+2 → data_out/valid_out at n+3.
- valid_out mirrors accepted-beat pattern (gaps preserved) in STREAM; suppressed in FILL.
- FLUSH: DEPTH consecutive valid_out cycles, first 3 cycles after flush accept.
- Config write visible to the next accepted beat.
- Reset mid-frame discards buffered data; tables return to identity.

## Structure
- Package spn_pkg: state enum (EMPTY, FILL, STREAM, FLUSH), cfg_table enum, derived-width helpers.
- Sub-module spn_bank_ram: one per channel, 2·DEPTH×DATA_WIDTH, independent write/read addresses, registered read, bank select as address MSB.
- Tables as flop arrays in top level; muxes via generate loops.

## Test plan
- Identity: reset, two frames, word c of beat t = {t,c}; frame-1 output = frame-0 input unchanged; first valid_out DEPTH+3 cycles after first beat.
- perm0[t][c]=(c+1)%PARA all t: output word c = {t,(c+1)%PARA}.
- wr_addr[t][c]=(t+c)%DEPTH: output beat t, channel c = {(t−c)%DEPTH, c}.
- Input every other cycle: valid_out alternates identically, 3 cycles late, data as identity case.
- Two frames then flush: DEPTH back-to-back frame-1 outputs, in_ready low DEPTH cycles, then busy=0; valid_in during FLUSH not accepted.
- cfg_wen while busy → cfg_err pulse, no table change; rst mid-frame → valid_out, data_out 0 immediately, identity behaviour restored.

Source files
------------

// File: rtl/spn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spn_pkg
// Brief   : Shared types and width helpers for the configurable SPN stream.
// Rev     : 1.0
// ============================================================================
package spn_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } spn_state_e;

    typedef enum logic [1:0] {
        CFG_PERM0 = 2'd0,
        CFG_MEM   = 2'd1,
        CFG_PERM2 = 2'd2,
        CFG_RSVD  = 2'd3
    } spn_cfg_table_e;

    function automatic int spn_cfg_w(input int sel_w, input int addr_w);
        return (sel_w > addr_w) ? sel_w : addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spn_bank_ram.sv
`default_nettype none
// ============================================================================
// Module  : spn_bank_ram
// Brief   : Ping-pong word RAM for one channel; bank select is the address MSB.
// Rev     : 1.0
// ============================================================================
module spn_bank_ram #(
    parameter  int DEPTH      = 16,
    parameter  int DATA_WIDTH = 32,
    localparam int AW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/spn_cfg_stream.sv
`default_nettype none
// ============================================================================
// Module  : spn_cfg_stream
// Brief   : Runtime-configurable spatial/temporal/spatial streaming permutation.
// Rev     : 1.0
// ============================================================================
module spn_cfg_stream
    import spn_pkg::*;
#(
    parameter  int PARA       = 16,
    parameter  int DEPTH      = 16,
    parameter  int DATA_WIDTH = 32,
    localparam int SEL_W      = $clog2(PARA),
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int CFG_W      = spn_cfg_w(SEL_W, ADDR_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in [PARA],
    input  logic                  flush,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out [PARA],
    output logic                  busy,
    input  logic                  cfg_wen,
    input  logic [1:0]            cfg_table,
    input  logic [ADDR_W-1:0]     cfg_beat,
    input  logic [SEL_W-1:0]      cfg_chan,
    input  logic [CFG_W-1:0]      cfg_data,
    output logic                  cfg_err
);

    localparam logic [ADDR_W-1:0] C_T_LAST = ADDR_W'(DEPTH - 1);

    spn_state_e            r_state;
    logic [ADDR_W-1:0]     r_t;
    logic                  r_wb;

    logic [SEL_W-1:0]      r_perm0 [DEPTH][PARA];
    logic [SEL_W-1:0]      r_perm2 [DEPTH][PARA];
    logic [ADDR_W-1:0]     r_wra   [DEPTH][PARA];

    logic                  r_s0_v, r_s0_we, r_s0_out, r_s0_wb;
    logic [ADDR_W-1:0]     r_s0_t;
    logic [DATA_WIDTH-1:0] r_s0_data [PARA];
    logic [ADDR_W-1:0]     r_s0_wa   [PARA];
    logic                  r_s1_v, r_s1_out;
    logic [ADDR_W-1:0]     r_s1_t;

    logic [DATA_WIDTH-1:0] w_m     [PARA];
    logic [ADDR_W-1:0]     w_wa    [PARA];
    logic [DATA_WIDTH-1:0] w_rdata [PARA];
    logic [DATA_WIDTH-1:0] w_out   [PARA];

    logic w_accept, w_issue, w_last, w_flush_go;

    assign in_ready   = (r_state != ST_FLUSH);
    assign w_accept   = valid_in && in_ready;
    // Flush beats are internal: they read the held bank but never write it.
    assign w_issue    = w_accept || (r_state == ST_FLUSH);
    assign w_last     = (r_t == C_T_LAST);
    assign w_flush_go = flush && !valid_in && (r_state == ST_STREAM) && (r_t == '0);
    assign busy       = (r_state != ST_EMPTY) || r_s0_v || r_s1_v || valid_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_t     <= '0;
            r_wb    <= 1'b0;
        end else if (w_issue) begin
            r_t <= r_t + 1'b1;
            if (w_last) begin
                r_wb <= ~r_wb;
            end
            case (r_state)
                ST_EMPTY:  r_state <= ST_FILL;
                ST_FILL:   if (w_last) r_state <= ST_STREAM;
                ST_FLUSH:  if (w_last) r_state <= ST_EMPTY;
                default:   r_state <= r_state;
            endcase
        end else if (w_flush_go) begin
            r_state <= ST_FLUSH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < DEPTH; t++) begin
                for (int c = 0; c < PARA; c++) begin
                    r_perm0[t][c] <= SEL_W'(c);
                    r_perm2[t][c] <= SEL_W'(c);
                    r_wra[t][c]   <= ADDR_W'(t);
                end
            end
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wen && busy && (spn_cfg_table_e'(cfg_table) != CFG_RSVD);
            if (cfg_wen && !busy) begin
                case (spn_cfg_table_e'(cfg_table))
                    CFG_PERM0: r_perm0[cfg_beat][cfg_chan] <= cfg_data[SEL_W-1:0];
                    CFG_MEM:   r_wra[cfg_beat][cfg_chan]   <= cfg_data[ADDR_W-1:0];
                    CFG_PERM2: r_perm2[cfg_beat][cfg_chan] <= cfg_data[SEL_W-1:0];
                    default:   ;
                endcase
            end
        end
    end

    for (genvar c = 0; c < PARA; c++) begin : g_chan
        assign w_m[c]   = data_in[r_perm0[r_t][c]];
        assign w_wa[c]  = r_wra[r_t][c];
        assign w_out[c] = w_rdata[r_perm2[r_s1_t][c]];

        spn_bank_ram #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ram (
            .clk     (clk),
            .i_we    (r_s0_we),
            .i_waddr ({r_s0_wb, r_s0_wa[c]}),
            .i_wdata (r_s0_data[c]),
            .i_raddr ({~r_s0_wb, r_s0_t}),
            .o_rdata (w_rdata[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_v   <= 1'b0;
            r_s0_we  <= 1'b0;
            r_s0_out <= 1'b0;
            r_s0_wb  <= 1'b0;
            r_s0_t   <= '0;
            for (int c = 0; c < PARA; c++) begin
                r_s0_data[c] <= '0;
                r_s0_wa[c]   <= '0;
            end
        end else begin
            r_s0_v   <= w_issue;
            r_s0_we  <= w_accept;
            r_s0_out <= w_issue && ((r_state == ST_STREAM) || (r_state == ST_FLUSH));
            r_s0_wb  <= r_wb;
            r_s0_t   <= r_t;
            if (w_issue) begin
                for (int c = 0; c < PARA; c++) begin
                    r_s0_data[c] <= w_m[c];
                    r_s0_wa[c]   <= w_wa[c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_out  <= 1'b0;
            r_s1_t    <= '0;
            valid_out <= 1'b0;
            for (int c = 0; c < PARA; c++) begin
                data_out[c] <= '0;
            end
        end else begin
            r_s1_v    <= r_s0_v;
            r_s1_out  <= r_s0_out;
            r_s1_t    <= r_s0_t;
            valid_out <= r_s1_out;
            if (r_s1_out) begin
                for (int c = 0; c < PARA; c++) begin
                    data_out[c] <= w_out[c];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spn_cfg_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_spn_cfg_stream
// Brief   : Directed self-checking bench for spn_cfg_stream.
// Rev     : 1.0
// ============================================================================
module tb_spn_cfg_stream;

    localparam int PARA  = 16;
    localparam int DEPTH = 16;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_in  [PARA];
    logic          flush = 1'b0;
    logic          valid_out;
    logic [DW-1:0] data_out [PARA];
    logic          busy;
    logic          cfg_wen = 1'b0;
    logic [1:0]    cfg_table = 2'd0;
    logic [3:0]    cfg_beat = 4'd0;
    logic [3:0]    cfg_chan = 4'd0;
    logic [3:0]    cfg_data = 4'd0;
    logic          cfg_err;

    spn_cfg_stream #(.PARA(PARA), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .flush     (flush),
        .valid_out (valid_out),
        .data_out  (data_out),
        .busy      (busy),
        .cfg_wen   (cfg_wen),
        .cfg_table (cfg_table),
        .cfg_beat  (cfg_beat),
        .cfg_chan  (cfg_chan),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Active table shape: perm0=(c+a)%P, wr_addr=(t+b*c)%D, perm2=(c+d)%P
    int g_a = 0, g_b = 0, g_d = 0;

    int          exp_q[$];
    int          out_cnt = 0, first_out = -1, first_in = -1, prev_out = 0, nonconsec = 0;
    bit          mon_en = 1'b0, chk_valid = 1'b0;
    logic [31:0] cap_w;

    typedef struct {
        int a; int b; int d; int gap;
        int lat; int w01;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] mk_word(input int tag, input int t, input int c);
        return {tag[7:0], 8'h5A, t[7:0], c[7:0]};
    endfunction

    function automatic logic [31:0] exp_word(input int s, input int c, input int tag);
        int cp, t, src;
        cp  = (c + g_d) % PARA;
        t   = ((s - g_b * cp) % DEPTH + DEPTH) % DEPTH;
        src = (cp + g_a) % PARA;
        return mk_word(tag, t, src);
    endfunction

    always @(negedge clk) begin : mon
        bit exp_v;
        int bad, ch, s, tg;
        if (mon_en) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0] == cyc);
            if (exp_v) void'(exp_q.pop_front());
            if (chk_valid) chk(valid_out == exp_v, "valid_out_pattern", valid_out, exp_v);
            if (valid_out) begin
                s   = out_cnt % DEPTH;
                tg  = out_cnt / DEPTH;
                bad = -1;
                for (int c = 0; c < PARA; c++)
                    if (bad < 0 && data_out[c] !== exp_word(s, c, tg)) bad = c;
                ch = (bad < 0) ? 0 : bad;
                chk(bad < 0, "data_out_word", data_out[ch], exp_word(s, ch, tg));
                if (out_cnt == 0) cap_w = data_out[1];
                if (out_cnt > DEPTH && cyc != prev_out + 1) nonconsec++;
                if (first_out < 0) first_out = cyc;
                prev_out = cyc;
                out_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_wr(input int tbl, input int t, input int c, input int d);
        cfg_wen   = 1'b1;
        cfg_table = 2'(tbl);
        cfg_beat  = 4'(t);
        cfg_chan  = 4'(c);
        cfg_data  = 4'(d);
        tick();
        cfg_wen   = 1'b0;
    endtask

    task automatic load_tables();
        for (int t = 0; t < DEPTH; t++) begin
            for (int c = 0; c < PARA; c++) begin
                cfg_wr(0, t, c, (c + g_a) % PARA);
                cfg_wr(1, t, c, (t + g_b * c) % DEPTH);
                cfg_wr(2, t, c, (c + g_d) % PARA);
            end
        end
    endtask

    task automatic drive_beat(input int t, input int tag, input int gap);
        valid_in = 1'b1;
        for (int c = 0; c < PARA; c++) data_in[c] = mk_word(tag, t, c);
        if (tag == 0 && t == 0) first_in = cyc;
        if (tag >= 1) exp_q.push_back(cyc + 3);
        tick();
        valid_in = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic run_frames(input int gap, input int lat, input string name);
        exp_q.delete();
        out_cnt = 0; first_out = -1; first_in = -1; nonconsec = 0; prev_out = 0;
        chk_valid = 1'b1;
        mon_en    = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int t = 0; t < DEPTH; t++) drive_beat(t, f, gap);
        repeat (8) tick();
        chk(out_cnt == DEPTH, {name, "_out_count"}, out_cnt, DEPTH);
        chk(first_out - first_in == lat, {name, "_latency"}, first_out - first_in, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit zero_ok;
        int lowcnt;

        for (int c = 0; c < PARA; c++) data_in[c] = '0;

        vecs[0] = '{a:0, b:0, d:0, gap:0, lat:19, w01:'h0001};
        vecs[1] = '{a:1, b:0, d:0, gap:0, lat:19, w01:'h0002};
        vecs[2] = '{a:0, b:1, d:0, gap:0, lat:19, w01:'h0F01};
        vecs[3] = '{a:0, b:0, d:3, gap:1, lat:35, w01:'h0004};
        vecs[4] = '{a:5, b:3, d:7, gap:2, lat:51, w01:'h080D};

        #12;
        zero_ok = 1'b1;
        for (int c = 0; c < PARA; c++) if (data_out[c] !== '0) zero_ok = 1'b0;
        chk(valid_out == 1'b0, "reset_valid_out", valid_out, 0);
        chk(zero_ok, "reset_data_out", data_out[0], 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        chk(cfg_err == 1'b0, "reset_cfg_err", cfg_err, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            g_a = vecs[i].a; g_b = vecs[i].b; g_d = vecs[i].d;
            do_reset();
            load_tables();
            chk(cfg_err == 1'b0, $sformatf("vec%0d_cfg_err_idle", i), cfg_err, 0);
            run_frames(vecs[i].gap, vecs[i].lat, $sformatf("vec%0d", i));
            chk(cap_w[15:0] == 16'(vecs[i].w01), $sformatf("vec%0d_beat0_ch1", i),
                cap_w[15:0], vecs[i].w01);
        end

        // Flush after two identity frames
        g_a = 0; g_b = 0; g_d = 0;
        do_reset();
        run_frames(0, 19, "flush_pre");
        chk_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        valid_in = 1'b1;
        for (int c = 0; c < PARA; c++) data_in[c] = mk_word(8'hEE, 0, c);
        lowcnt = 0;
        for (int i = 0; i < DEPTH + 4 && !in_ready; i++) begin
            lowcnt++;
            tick();
        end
        valid_in = 1'b0;
        chk(lowcnt == DEPTH, "flush_ready_low_cycles", lowcnt, DEPTH);
        for (int i = 0; i < 10 && busy; i++) tick();
        chk(busy == 1'b0, "flush_busy_drop", busy, 0);
        chk(out_cnt == 2 * DEPTH, "flush_out_count", out_cnt, 2 * DEPTH);
        chk(nonconsec == 0, "flush_back_to_back", nonconsec, 0);

        // Config write while busy must be rejected
        g_a = 5; g_b = 3; g_d = 7;
        do_reset();
        load_tables();
        cfg_wr(3, 0, 0, 9);
        chk(cfg_err == 1'b0, "cfg_rsvd_no_err", cfg_err, 0);
        exp_q.delete();
        out_cnt = 0; first_out = -1;
        chk_valid = 1'b1;
        mon_en    = 1'b1;
        for (int t = 0; t < 4; t++) drive_beat(t, 0, 0);
        cfg_wen = 1'b1; cfg_table = 2'd0; cfg_beat = 4'd0; cfg_chan = 4'd0; cfg_data = 4'd9;
        drive_beat(4, 0, 0);
        cfg_wen = 1'b0;
        chk(cfg_err == 1'b1, "cfg_err_busy", cfg_err, 1);
        drive_beat(5, 0, 0);
        chk(cfg_err == 1'b0, "cfg_err_one_cycle", cfg_err, 0);
        for (int t = 6; t < DEPTH; t++) drive_beat(t, 0, 0);
        for (int t = 0; t < DEPTH; t++) drive_beat(t, 1, 0);
        repeat (8) tick();
        chk(out_cnt == DEPTH, "cfg_busy_out_count", out_cnt, DEPTH);

        // Reset in the middle of a streaming frame
        mon_en = 1'b0;
        for (int t = 0; t < 5; t++) drive_beat(t, 2, 0);
        chk(valid_out == 1'b1, "pre_reset_valid", valid_out, 1);
        rst = 1'b1;
        #1;
        zero_ok = 1'b1;
        for (int c = 0; c < PARA; c++) if (data_out[c] !== '0) zero_ok = 1'b0;
        chk(valid_out == 1'b0, "midrst_valid_out", valid_out, 0);
        chk(zero_ok, "midrst_data_out", data_out[0], 0);
        chk(busy == 1'b0, "midrst_busy", busy, 0);
        chk(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        g_a = 0; g_b = 0; g_d = 0;
        run_frames(0, 19, "post_reset_identity");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
